// File: rtl/denise_pkg.sv
// Shared types and constants for the Denise colour-table write controller.
package denise_pkg;

  localparam logic [7:0] BPLCON3_ADDR = 8'h83;
  // reg_addr[7:5] of COLOR00..COLOR31 (chip addresses 0x180..0x1BE)
  localparam logic [2:0] COLOR_BASE   = 3'b110;
  localparam logic [3:0] BE_ALL       = 4'b1111;
  localparam logic [3:0] BE_LOCT      = 4'b1100;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ct_entry_t;

  typedef enum logic {
    INIT,
    RUN
  } ct_state_e;

  function automatic logic [31:0] pack_rgb(input logic [11:0] rgb);
    return {4'h0, rgb, 4'h0, rgb};
  endfunction

endpackage

// File: rtl/denise_ct_wrfifo.sv
// Small synchronous FIFO of palette write entries; a push into a full FIFO
// is still accepted when a pop happens in the same cycle.
module denise_ct_wrfifo
  import denise_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      push_i,
  input  ct_entry_t entry_i,
  input  logic      pop_i,
  output ct_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  ct_entry_t     mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: it is only read once the count says it is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/denise_colortable_wrctl.sv
// Palette RAM write controller: clears the palette after reset, then queues
// COLORxx writes. DENISE_AGA_EN enables BPLCON3 bank/LOCT and a 256-entry clear.
module denise_colortable_wrctl
  import denise_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ena,
  input  logic [7:0]  reg_addr,
  input  logic [15:0] reg_data,
  input  logic        reg_wr,
  output logic        ct_wren,
  output logic [7:0]  ct_wraddress,
  output logic [31:0] ct_data,
  output logic [3:0]  ct_byteena,
  output logic        init_done,
  output logic        ovf
);

  logic [2:0] bank;
  logic       loct;
  logic       unused_bits;

`ifdef DENISE_AGA_EN
  localparam logic [7:0] CLR_LAST = 8'd255;
  logic [2:0] bank_q;
  logic       loct_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bank_q <= 3'b000;
      loct_q <= 1'b0;
    end else if (reg_wr && reg_addr == BPLCON3_ADDR) begin
      bank_q <= reg_data[15:13];
      loct_q <= reg_data[9];
    end
  end

  assign bank        = bank_q;
  assign loct        = loct_q;
  assign unused_bits = ^{reg_data[12], reg_data[10]};
`else
  localparam logic [7:0] CLR_LAST = 8'd31;
  assign bank        = 3'b000;
  assign loct        = 1'b0;
  assign unused_bits = ^reg_data[15:12];
`endif

  ct_state_e  state_q, state_d;
  logic [7:0] clr_cnt_q, clr_cnt_d;
  logic       init_done_q, init_done_d;
  logic       ovf_q, ovf_d;
  logic       color_wr, fifo_pop, fifo_full, fifo_empty;
  ct_entry_t  push_entry, head;

  // The entry is frozen with the bank/LOCT in force at push time.
  assign color_wr        = reg_wr & (reg_addr[7:5] == COLOR_BASE);
  assign push_entry.addr = {bank, reg_addr[4:0]};
  assign push_entry.data = pack_rgb(reg_data[11:0]);
  assign push_entry.be   = loct ? BE_LOCT : BE_ALL;

  denise_ct_wrfifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (color_wr),
    .entry_i (push_entry),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      clr_cnt_q   <= 8'd0;
      init_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    init_done_d  = init_done_q;
    fifo_pop     = 1'b0;
    ct_wren      = 1'b1;
    ct_wraddress = clr_cnt_q;
    ct_data      = 32'h0;
    ct_byteena   = BE_ALL;
    case (state_q)
      INIT: begin
        if (ena) begin
          if (clr_cnt_q == CLR_LAST) begin
            state_d     = RUN;
            init_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + 8'd1;
          end
        end
      end
      RUN: begin
        ct_wren      = ~fifo_empty;
        ct_wraddress = head.addr;
        ct_data      = head.data;
        ct_byteena   = head.be;
        fifo_pop     = ena & ~fifo_empty;
      end
      default: state_d = INIT;
    endcase
    // A pop in the same cycle frees the slot, so only a true overflow drops.
    ovf_d = ovf_q | (color_wr & fifo_full & ~fifo_pop);
  end

  assign init_done = init_done_q;
  assign ovf       = ovf_q;

endmodule
